natv_dma_initiator: RTL and testbench

Word-copy engine that masters the native (natv) memory bus. It accepts a copy command (source, destination, length in words) and issues alternating natv read and write transfers through any natv responder: SRAM, PSRAM window or the peripheral register block. The source and destination addresses can each be held fixed, for FIFO-style data registers such as the UART data register. Each transfer is bounded by a ready timeout, and each word is either copied completely or not at all.

---
 rtl/natv_pkg.sv | 17 +
 rtl/natv_timeout_cnt.sv | 37 +++
 rtl/natv_dma_initiator.sv | 142 ++++++++++++++
 tb/tb_natv_dma_initiator.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/natv_pkg.sv
// Shared types for the natv bus master: copy-engine state encoding and write-strobe values.
// Pure declarations; no logic, latency or backpressure of its own.
package natv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WSET,
      ST_WR,
      ST_NEXT,
      ST_FIN
   } natv_state_t;

   localparam logic [3:0] NATV_WSTRB_RD = 4'h0;
   localparam logic [3:0] NATV_WSTRB_WR = 4'hF;

endpackage

// File: rtl/natv_timeout_cnt.sv
// Per-transfer ready timeout: counts waiting cycles; expired_o is combinational in the waiting
// cycle that reaches TIMEOUT_CYC (never asserts when TIMEOUT_CYC is 0).
module natv_timeout_cnt #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the waiting cycles already spent, so this cycle is number cnt_q+1.
   assign expired_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/natv_dma_initiator.sv
// Word-copy engine mastering the natv bus: one read then one write per word, 6 cycles/word with a
// 1-cycle responder; waits on natv_ready_i per transfer, bounded by TIMEOUT_CYC; cmd_ready_o only in IDLE.
module natv_dma_initiator
   import natv_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255,
   parameter int LEN_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [31:0]      cmd_src_i,
   input  logic [31:0]      cmd_dst_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   input  logic             cmd_src_inc_i,
   input  logic             cmd_dst_inc_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_o,
   output logic [LEN_W-1:0] xfer_cnt_o,
   output logic             natv_valid_o,
   output logic [31:0]      natv_addr_o,
   output logic [31:0]      natv_wdata_o,
   output logic [3:0]       natv_wstrb_o,
   input  logic [31:0]      natv_rdata_i,
   input  logic             natv_ready_i
);

   natv_state_t      state_q, state_d;
   logic [31:0]      src_q, src_d, dst_q, dst_d, data_q, data_d;
   logic [LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
   logic             src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
   logic             abort_q, abort_d, err_q, err_d;
   logic             in_xfer, tmo_expired;

   assign in_xfer = (state_q == ST_RD) || (state_q == ST_WR);

   // Counter is held clear outside RD/WR, so it restarts on every entry to a transfer.
   natv_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_tmo (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clr_i     (!in_xfer),
      .en_i      (in_xfer && !natv_ready_i),
      .expired_o (tmo_expired)
   );

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      data_d    = data_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      src_inc_d = src_inc_q;
      dst_inc_d = dst_inc_q;
      err_d     = err_q;
      abort_d   = abort_q || ((state_q != ST_IDLE) && abort_i);
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid_i) begin
               src_d     = cmd_src_i & 32'hFFFF_FFFC;
               dst_d     = cmd_dst_i & 32'hFFFF_FFFC;
               len_d     = cmd_len_i;
               src_inc_d = cmd_src_inc_i;
               dst_inc_d = cmd_dst_inc_i;
               cnt_d     = '0;
               abort_d   = 1'b0;
               err_d     = 1'b0;
               state_d   = (cmd_len_i == '0) ? ST_FIN : ST_RD;
            end
         end
         ST_RD: begin
            // A ready arriving in the expiring cycle still completes the transfer.
            if (natv_ready_i) begin
               data_d  = natv_rdata_i;
               state_d = ST_WSET;
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_WSET: state_d = ST_WR;
         ST_WR: begin
            if (natv_ready_i) begin
               cnt_d   = cnt_q + LEN_W'(1);
               state_d = ST_NEXT;
            end else if (tmo_expired) begin
               err_d   = 1'b1;
               state_d = ST_FIN;
            end
         end
         ST_NEXT: begin
            src_d   = src_inc_q ? src_q + 32'd4 : src_q;
            dst_d   = dst_inc_q ? dst_q + 32'd4 : dst_q;
            state_d = ((cnt_q == len_q) || abort_q) ? ST_FIN : ST_RD;
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         data_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         src_inc_q <= 1'b0;
         dst_inc_q <= 1'b0;
         abort_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         src_q     <= src_d;
         dst_q     <= dst_d;
         data_q    <= data_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         src_inc_q <= src_inc_d;
         dst_inc_q <= dst_inc_d;
         abort_q   <= abort_d;
         err_q     <= err_d;
      end
   end

   assign cmd_ready_o  = (state_q == ST_IDLE);
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = (state_q == ST_FIN);
   assign err_o        = (state_q == ST_FIN) && err_q;
   assign xfer_cnt_o   = cnt_q;
   assign natv_valid_o = in_xfer;
   assign natv_addr_o  = (state_q == ST_RD) ? src_q : ((state_q == ST_WR) ? dst_q : 32'h0);
   assign natv_wdata_o = ((state_q == ST_WSET) || (state_q == ST_WR)) ? data_q : 32'h0;
   assign natv_wstrb_o = (state_q == ST_WR) ? NATV_WSTRB_WR : NATV_WSTRB_RD;

endmodule

// File: tb/tb_natv_dma_initiator.sv
// Bench for natv_dma_initiator: randomized copy commands against a transfer-list/cycle-count model,
// with a delay-programmable natv responder and a bus-stability monitor.
module tb_natv_dma_initiator;

   localparam int TMO = 8;
   localparam int LW  = 16;

   logic          clk_i;
   logic          rst_i;
   logic          cmd_valid_i;
   logic          cmd_ready_o;
   logic [31:0]   cmd_src_i;
   logic [31:0]   cmd_dst_i;
   logic [LW-1:0] cmd_len_i;
   logic          cmd_src_inc_i;
   logic          cmd_dst_inc_i;
   logic          abort_i;
   logic          busy_o;
   logic          done_o;
   logic          err_o;
   logic [LW-1:0] xfer_cnt_o;
   logic          natv_valid_o;
   logic [31:0]   natv_addr_o;
   logic [31:0]   natv_wdata_o;
   logic [3:0]    natv_wstrb_o;
   logic [31:0]   natv_rdata_i;
   logic          natv_ready_i;

   natv_dma_initiator #(
      .TIMEOUT_CYC (TMO),
      .LEN_W       (LW)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .cmd_valid_i   (cmd_valid_i),
      .cmd_ready_o   (cmd_ready_o),
      .cmd_src_i     (cmd_src_i),
      .cmd_dst_i     (cmd_dst_i),
      .cmd_len_i     (cmd_len_i),
      .cmd_src_inc_i (cmd_src_inc_i),
      .cmd_dst_inc_i (cmd_dst_inc_i),
      .abort_i       (abort_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .xfer_cnt_o    (xfer_cnt_o),
      .natv_valid_o  (natv_valid_o),
      .natv_addr_o   (natv_addr_o),
      .natv_wdata_o  (natv_wdata_o),
      .natv_wstrb_o  (natv_wstrb_o),
      .natv_rdata_i  (natv_rdata_i),
      .natv_ready_i  (natv_ready_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
      logic [31:0] rdata;
   } xfer_t;

   int    n_chk   = 0;
   int    n_fail  = 0;
   int    seq     = 0;
   int    bus_err = 0;
   int    abort_w = -1;
   int    dly[16];          // extra wait cycles per transfer index; -1 = never answer
   xfer_t xlog_q[$];

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Responder plus bus monitor, all updated on the falling edge.
   int          last_seq;
   int          tix;
   int          wait_left;
   logic        active, prev_valid, prev_rdy;
   logic [31:0] prev_addr, prev_wdata, rd_word;
   logic [3:0]  prev_wstrb;

   initial begin
      natv_ready_i = 1'b0;
      natv_rdata_i = 32'h0;
      abort_i      = 1'b0;
      last_seq     = 0;
      tix          = 0;
      wait_left    = 0;
      active       = 1'b0;
      prev_valid   = 1'b0;
      prev_rdy     = 1'b0;
      prev_addr    = 32'h0;
      prev_wdata   = 32'h0;
      prev_wstrb   = 4'h0;
      rd_word      = 32'h0;
      forever begin
         @(negedge clk_i);
         abort_i      = 1'b0;
         natv_rdata_i = $urandom;
         if (natv_valid_o && prev_valid) begin
            if (prev_rdy)
               bus_err++;
            else if (natv_addr_o !== prev_addr || natv_wdata_o !== prev_wdata ||
                     natv_wstrb_o !== prev_wstrb)
               bus_err++;
         end
         prev_valid = natv_valid_o;
         prev_addr  = natv_addr_o;
         prev_wdata = natv_wdata_o;
         prev_wstrb = natv_wstrb_o;
         if (seq != last_seq) begin
            last_seq = seq;
            tix      = 0;
            active   = 1'b0;
            xlog_q.delete();
         end
         if (natv_ready_i) begin
            natv_ready_i = 1'b0;
            active       = 1'b0;
         end else if (natv_valid_o) begin
            if (!active) begin
               xfer_t x;
               active    = 1'b1;
               wait_left = (tix < 16) ? dly[tix] : 0;
               rd_word   = $urandom;
               x.addr    = natv_addr_o;
               x.wstrb   = natv_wstrb_o;
               x.wdata   = natv_wdata_o;
               x.rdata   = rd_word;
               xlog_q.push_back(x);
               if (abort_w >= 0 && tix == 2 * abort_w) abort_i = 1'b1;
               tix++;
            end else if (wait_left == 0) begin
               natv_ready_i = 1'b1;
               natv_rdata_i = rd_word;
            end else if (wait_left > 0) begin
               wait_left--;
            end
         end else begin
            active = 1'b0;
         end
         prev_rdy = natv_ready_i;
      end
   end

   task automatic set_dly(input int v);
      for (int i = 0; i < 16; i++) dly[i] = v;
      abort_w = -1;
   endtask

   task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int len,
                          input logic si, input logic di, input string nm);
      xfer_t exp_q[$];
      int    cyc_e = 1;
      int    cnt_e = 0;
      int    err_e = 0;
      int    cyc;
      int    seen;
      int    n;
      // Expected transfer list and done cycle: each completed transfer costs ready-delay+2
      // valid cycles plus one idle gap cycle; a dead transfer costs TMO cycles and ends the command.
      for (int w = 0; w < len; w++) begin
         xfer_t e;
         e.addr  = (s & 32'hFFFF_FFFC) + (si ? (32'(w) << 2) : 32'h0);
         e.wstrb = 4'h0;
         e.wdata = 32'h0;
         e.rdata = 32'h0;
         exp_q.push_back(e);
         if (dly[2*w] < 0) begin cyc_e += TMO; err_e = 1; break; end
         cyc_e += dly[2*w] + 3;
         e.addr  = (d & 32'hFFFF_FFFC) + (di ? (32'(w) << 2) : 32'h0);
         e.wstrb = 4'hF;
         exp_q.push_back(e);
         if (dly[2*w+1] < 0) begin cyc_e += TMO; err_e = 1; break; end
         cyc_e += dly[2*w+1] + 3;
         cnt_e++;
         if (w == abort_w) break;
      end

      @(negedge clk_i);
      chk({nm, ":cmd_ready"}, 32'(cmd_ready_o), 32'd1);
      seq++;
      cmd_src_i     = s;
      cmd_dst_i     = d;
      cmd_len_i     = LW'(len);
      cmd_src_inc_i = si;
      cmd_dst_inc_i = di;
      cmd_valid_i   = 1'b1;
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
      cyc  = 1;
      seen = 0;
      while (cyc < 2000) begin
         @(negedge clk_i);
         if (done_o) begin seen = 1; break; end
         cyc++;
      end
      chk({nm, ":done_seen"}, 32'(seen), 32'd1);
      chk({nm, ":done_cycle"}, 32'(cyc), 32'(cyc_e));
      chk({nm, ":err"}, 32'(err_o), 32'(err_e));
      chk({nm, ":xfer_cnt"}, 32'(xfer_cnt_o), 32'(cnt_e));
      @(negedge clk_i);
      chk({nm, ":done_pulse"}, 32'(done_o), 32'd0);
      chk({nm, ":ready_after"}, 32'(cmd_ready_o), 32'd1);
      chk({nm, ":n_xfer"}, 32'(xlog_q.size()), 32'(exp_q.size()));
      n = (xlog_q.size() < exp_q.size()) ? xlog_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s:addr[%0d]", nm, i), xlog_q[i].addr, exp_q[i].addr);
         chk($sformatf("%s:wstrb[%0d]", nm, i), 32'(xlog_q[i].wstrb), 32'(exp_q[i].wstrb));
         if (i % 2 == 1)
            chk($sformatf("%s:wdata[%0d]", nm, i), xlog_q[i].wdata, xlog_q[i-1].rdata);
      end
   endtask

   initial begin
      int seen;
      int len;
      int mode;
      rst_i         = 1'b1;
      cmd_valid_i   = 1'b0;
      cmd_src_i     = 32'h0;
      cmd_dst_i     = 32'h0;
      cmd_len_i     = '0;
      cmd_src_inc_i = 1'b0;
      cmd_dst_inc_i = 1'b0;
      set_dly(0);
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst:cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst:busy", 32'(busy_o), 32'd0);
      chk("rst:done", 32'(done_o), 32'd0);
      chk("rst:err", 32'(err_o), 32'd0);
      chk("rst:valid", 32'(natv_valid_o), 32'd0);
      chk("rst:xfer_cnt", 32'(xfer_cnt_o), 32'd0);
      chk("rst:addr", natv_addr_o, 32'h0);
      chk("rst:wstrb", 32'(natv_wstrb_o), 32'h0);
      rst_i = 1'b0;

      set_dly(0);
      run_cmd(32'h1000, 32'h2000, 3, 1'b1, 1'b1, "basic");
      set_dly(3);
      run_cmd(32'h3000, 32'h1004, 4, 1'b1, 1'b0, "fixdst");
      set_dly(0);
      run_cmd(32'h0010, 32'h0020, 0, 1'b1, 1'b1, "len0");
      set_dly(0); dly[2] = -1;
      run_cmd(32'h4000, 32'h5000, 3, 1'b1, 1'b1, "timeout");
      set_dly(0); dly[1] = -1;
      run_cmd(32'h4100, 32'h5100, 2, 1'b1, 1'b1, "timeout_wr");
      set_dly(0); dly[1] = TMO - 2;
      run_cmd(32'h6000, 32'h6100, 2, 1'b0, 1'b1, "ready_wins");
      set_dly(0); abort_w = 1;
      run_cmd(32'h7000, 32'h7800, 5, 1'b1, 1'b1, "abort");
      set_dly(1);
      run_cmd(32'hFFFF_FFFD, 32'h7FFF_FFFE, 2, 1'b1, 1'b1, "wrap");

      // Reset while the second word's write is waiting for ready.
      set_dly(0); dly[3] = 3;
      @(negedge clk_i);
      seq++;
      cmd_src_i = 32'h8000; cmd_dst_i = 32'h9000; cmd_len_i = LW'(3);
      cmd_src_inc_i = 1'b1; cmd_dst_inc_i = 1'b1; cmd_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      cmd_valid_i = 1'b0;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk_i);
         if (natv_valid_o && natv_wstrb_o == 4'hF && xfer_cnt_o == LW'(1)) begin
            seen = 1;
            break;
         end
      end
      chk("rstmid:reach_wr", 32'(seen), 32'd1);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("rstmid:valid", 32'(natv_valid_o), 32'd0);
      chk("rstmid:cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rstmid:xfer_cnt", 32'(xfer_cnt_o), 32'd0);
      chk("rstmid:busy", 32'(busy_o), 32'd0);
      set_dly(0);
      run_cmd(32'hA000, 32'hB000, 2, 1'b1, 1'b1, "post_rst");

      for (int it = 0; it < 24; it++) begin
         len  = $urandom_range(0, 6);
         mode = $urandom_range(0, 3);
         set_dly(0);
         for (int i = 0; i < 16; i++) dly[i] = $urandom_range(0, 3);
         if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, 11)] = TMO - 2;
         if (mode == 1 && len > 0) dly[$urandom_range(0, 2 * len - 1)] = -1;
         if (mode == 2) abort_w = $urandom_range(0, len);
         run_cmd($urandom, $urandom, len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $sformatf("rnd%0d", it));
      end

      chk("bus_rules", 32'(bus_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
